// File: rtl/sensor_cond.sv
// Conditions the four raw A2D channels on a fixed sample period: exponential
// averages for current and torque, hysteretic battery-low, debounced brake.
module sensor_cond #(
  parameter int unsigned SAMP_W    = 16,
  parameter logic [11:0] LOW_BATT  = 12'hA98,
  parameter logic [11:0] BATT_HYST = 12'h040,
  parameter logic [11:0] BRAKE_THR = 12'h800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] brake,
  input  logic [11:0] torque,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        batt_low,
  output logic        brake_on,
  output logic        smpl_vld
);

  typedef enum logic [2:0] {
    OFF,
    ON_PEND1,
    ON_PEND2,
    ON,
    OFF_PEND1,
    OFF_PEND2
  } brake_state_t;

  logic [SAMP_W-1:0] smpl_cnt;
  logic              smpl;
  logic [13:0]       acc_c;
  logic [16:0]       acc_t;
  logic              seeded;
  logic [12:0]       rel_thr;
  logic              brake_high;
  brake_state_t      state, state_nxt;

  assign smpl       = &smpl_cnt;
  assign rel_thr    = {1'b0, LOW_BATT} + {1'b0, BATT_HYST};
  assign brake_high = (brake > BRAKE_THR);
  assign avg_curr   = acc_c[13:2];
  assign avg_torque = acc_t[16:5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smpl_cnt <= '0;
      smpl_vld <= 1'b0;
    end else begin
      smpl_cnt <= smpl_cnt + 1'b1;
      smpl_vld <= smpl;
    end
  end

  // First strobe after reset loads the sample directly so averages start at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_c  <= '0;
      acc_t  <= '0;
      seeded <= 1'b0;
    end else if (smpl) begin
      seeded <= 1'b1;
      if (!seeded) begin
        acc_c <= {curr, 2'b00};
        acc_t <= {torque, 5'b0_0000};
      end else begin
        acc_c <= acc_c - (acc_c >> 2) + {2'b00, curr};
        acc_t <= acc_t - (acc_t >> 5) + {5'b0_0000, torque};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      batt_low <= 1'b0;
    end else if (smpl) begin
      if (batt < LOW_BATT)
        batt_low <= 1'b1;
      else if ({1'b0, batt} >= rel_thr)
        batt_low <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      brake_on <= 1'b0;
    end else begin
      state    <= state_nxt;
      brake_on <= (state_nxt == ON) || (state_nxt == OFF_PEND1) ||
                  (state_nxt == OFF_PEND2);
    end
  end

  always_comb begin
    state_nxt = state;
    if (smpl) begin
      case (state)
        OFF:       if (brake_high) state_nxt = ON_PEND1;
        ON_PEND1:  state_nxt = brake_high ? ON_PEND2 : OFF;
        ON_PEND2:  state_nxt = brake_high ? ON : OFF;
        ON:        if (!brake_high) state_nxt = OFF_PEND1;
        OFF_PEND1: state_nxt = brake_high ? ON : OFF_PEND2;
        OFF_PEND2: state_nxt = brake_high ? ON : OFF;
        default:   state_nxt = OFF;
      endcase
    end
  end

endmodule
